// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Valid/ready note: this block has no handshake; key_valid is a level qualifier for key_code.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        S_DRIVE   = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2
    } scan_state_t;

    // KEYMAP[row][col]; within each row the rightmost nibble is column 0.
    localparam logic [3:0][3:0][3:0] KEYMAP = {
        {4'hD, 4'hF, 4'h0, 4'hE},
        {4'hC, 4'h9, 4'h8, 4'h7},
        {4'hB, 4'h6, 4'h5, 4'h4},
        {4'hA, 4'h3, 4'h2, 4'h1}
    };

    // Lowest-index active-low row; only meaningful when at least one bit is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset to a configurable idle value.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one column low at a time, locks onto the first pressed key
// and reports it until its row goes idle for RELEASE_CYCLES.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int RELEASE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output scan_state_t dbg_state_o
);

    localparam int CNT_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

    logic [3:0] row_s;

    scan_state_t      state_q,     state_d;
    logic [1:0]       col_idx_q,   col_idx_d;
    logic [3:0]       col_n_q,     col_n_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       lock_row_q,  lock_row_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q,  key_code_d;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_n),
        .q_o   (row_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DRIVE;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            cnt_q       <= '0;
            lock_row_q  <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            cnt_q       <= cnt_d;
            lock_row_q  <= lock_row_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        lock_row_d  = lock_row_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        unique case (state_q)
            S_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (row_s == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        lock_row_d  = lowest_low_row(row_s);
                        key_code_d  = KEYMAP[lowest_low_row(row_s)][col_idx_q];
                        key_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (row_s[lock_row_q]) begin
                    key_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // A bounce back to pressed takes priority over the release timeout.
                if (!row_s[lock_row_q]) begin
                    key_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (cnt_q == RELEASE_LAST) begin
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = S_DRIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_DRIVE;
                cnt_d   = '0;
            end
        endcase
        col_n_d = ~(4'b0001 << col_idx_d);
    end

    always_comb begin
        col_n       = col_n_q;
        key_valid   = key_valid_q;
        key_code    = key_code_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model and a cycle-level reference model.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SETTLE  = 4;
    localparam int RELEASE = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    scan_state_t dbg_state;

    logic pressed [4][4];
    logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'hE, 4'h0, 4'hF, 4'hD}};

    int n_chk = 0;
    int n_err = 0;

    keypad_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .RELEASE_CYCLES (RELEASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad matrix ----------------
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // ---------------- reference model ----------------
    // mode: 0 scanning, 1 key held, 2 waiting for release to time out
    int         m_mode, m_col, m_cnt, m_lock;
    logic       m_valid;
    logic [3:0] m_code, m_s1, m_s2, m_rs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_col = 0; m_cnt = 0; m_lock = 0;
            m_valid = 1'b0; m_code = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            m_rs = m_s2;
            m_s2 = m_s1;
            m_s1 = row_n;
            if (m_mode == 0) begin
                if (m_cnt < SETTLE - 1) m_cnt++;
                else begin
                    m_cnt = 0;
                    if (m_rs == 4'hF) m_col = (m_col + 1) % 4;
                    else begin
                        m_lock = 0;
                        while (m_rs[m_lock]) m_lock++;
                        m_code = km[m_lock][m_col];
                        m_valid = 1'b1;
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (m_rs[m_lock]) begin
                    m_valid = 1'b0; m_cnt = 0; m_mode = 2;
                end
            end else begin
                if (!m_rs[m_lock]) begin
                    m_valid = 1'b1; m_mode = 1;
                end else if (m_cnt >= RELEASE - 1) begin
                    m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0;
                end else m_cnt++;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [3:0] exp_col;
        exp_col = ~(4'b0001 << m_col);
        chk("model_col_n", 32'(col_n), 32'(exp_col));
        chk("model_key_valid", 32'(key_valid), 32'(m_valid));
        chk("model_key_code", 32'(key_code), 32'(m_code));
        chk("col_onehot", 32'($onehot(~col_n)), 32'd1);
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            compare_model();
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic wait_valid(input logic level, input string name);
        int k;
        k = 0;
        while (key_valid !== level && k < 40) begin
            step(1);
            k++;
        end
        chk(name, 32'(key_valid), 32'(level));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_keys();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_col_n", 32'(col_n), 32'h0000000E);
        chk("reset_key_valid", 32'(key_valid), 32'd0);
        chk("reset_key_code", 32'(key_code), 32'd0);
        compare_model();
        rst_n = 1'b1;

        // 1: idle scan, 4 cycles per column
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_col;
            step(1);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            chk("idle_col_seq", 32'(col_n), 32'(exp_col));
            chk("idle_valid", 32'(key_valid), 32'd0);
        end

        // 2: hold (1,2), then release
        pressed[1][2] = 1'b1;
        wait_valid(1'b1, "t2_press_seen");
        chk("t2_code", 32'(key_code), 32'h6);
        chk("t2_col", 32'(col_n), 32'hB);
        step(5);
        chk("t2_col_frozen", 32'(col_n), 32'hB);
        chk("t2_still_valid", 32'(key_valid), 32'd1);
        pressed[1][2] = 1'b0;
        step(2);
        chk("t2_valid_latency", 32'(key_valid), 32'd1);
        step(1);
        chk("t2_valid_drop", 32'(key_valid), 32'd0);
        step(2);
        chk("t2_col_release_hold", 32'(col_n), 32'hB);
        step(1);
        chk("t2_col_resume", 32'(col_n), 32'h7);

        // 3: hold (3,1) with a one-cycle bounce
        pressed[3][1] = 1'b1;
        wait_valid(1'b1, "t3_press_seen");
        chk("t3_code", 32'(key_code), 32'h0);
        step(3);
        pressed[3][1] = 1'b0;
        step(1);
        pressed[3][1] = 1'b1;
        step(1);
        chk("t3_valid_before", 32'(key_valid), 32'd1);
        step(1);
        chk("t3_valid_bounce_low", 32'(key_valid), 32'd0);
        step(1);
        chk("t3_valid_back", 32'(key_valid), 32'd1);
        chk("t3_code_kept", 32'(key_code), 32'h0);
        chk("t3_col_kept", 32'(col_n), 32'hD);
        pressed[3][1] = 1'b0;
        wait_valid(1'b0, "t3_release");
        step(6);

        // 4: two keys in column 3
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        wait_valid(1'b1, "t4_press_seen");
        chk("t4_code_row0_wins", 32'(key_code), 32'hA);
        chk("t4_col", 32'(col_n), 32'h7);
        pressed[0][3] = 1'b0;
        step(3);
        chk("t4_valid_drop", 32'(key_valid), 32'd0);
        wait_valid(1'b1, "t4_rescan_seen");
        chk("t4_code_rescan", 32'(key_code), 32'hC);
        clear_keys();
        wait_valid(1'b0, "t4_release");
        step(6);

        // 5: async reset mid-hold
        pressed[2][0] = 1'b1;
        wait_valid(1'b1, "t5_press_seen");
        chk("t5_code", 32'(key_code), 32'h7);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(key_valid), 32'd0);
        chk("t5_async_col", 32'(col_n), 32'hE);
        #1;
        rst_n = 1'b1;
        wait_valid(1'b1, "t5_rereport_seen");
        chk("t5_rereport_code", 32'(key_code), 32'h7);
        clear_keys();
        wait_valid(1'b0, "t5_release");
        step(6);

        // 6: sweep every key
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                pressed[r][c] = 1'b1;
                wait_valid(1'b1, "t6_press_seen");
                chk("t6_sweep_code", 32'(key_code), 32'(km[r][c]));
                pressed[r][c] = 1'b0;
                wait_valid(1'b0, "t6_release");
                step(6);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
